tt_um_jleugeri_ttt_event_fifo: RTL

TT_UM_JLEUGERI_TTT_EVENT_FIFO -- requirements
Module: tt_um_jleugeri_ttt_event_fifo

---
 rtl/tt_um_jleugeri_ttt_event_fifo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Token event FIFO: queues (processor, start/stop[, step stamp]) events from the main core for a host to drain.
// Latency: a push is visible at the head one cycle after its edge when empty; head outputs are combinational from storage.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged via sticky overflow.
// Optional feature: define TTT_EVENT_TIMESTAMP_EN to stamp each entry with an 8-bit step counter.

// Generic single-clock FIFO with combinational head and full-with-pop pass-through.
// Latency: write visible at the read side one cycle after the write edge.
// Backpressure: wr_rdy drops only when full and the read side is not consuming this cycle.
module ttt_event_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == CW'(DEPTH));
  assign rd_vld  = (count != '0);
  // A full FIFO can still take a write when the head leaves on the same edge.
  assign wr_rdy  = !full || rd_rdy;
  assign rd_fire = rd_rdy && rd_vld;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset since occupancy is zero.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

endmodule

module tt_um_jleugeri_ttt_event_fifo #(
  parameter int NUM_PROCESSORS = 8,
  parameter int DEPTH = 8,
  localparam int PW = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock_fast,
  input  logic          reset,
  input  logic [PW-1:0] processor_id_in,
  input  logic [1:0]    token_startstop_in,
  input  logic          output_valid_in,
  input  logic [1:0]    stage_in,
  input  logic          pop,
  input  logic          clear_overflow,
  output logic          event_valid,
  output logic [PW-1:0] event_proc_id,
  output logic [1:0]    event_startstop,
  output logic [7:0]    event_timestamp,
  output logic [CW-1:0] count,
  output logic          overflow
);

  typedef struct packed {
    logic [PW-1:0] proc_id;
    logic [1:0]    startstop;
`ifdef TTT_EVENT_TIMESTAMP_EN
    logic [7:0]    timestamp;
`endif
  } entry_t;

  entry_t push_dat;
  entry_t head_dat;
  logic   push_vld;
  logic   push_rdy;
  logic   drop_vld;

  // Events carrying neither a start nor a stop token are not worth queueing.
  assign push_vld = output_valid_in && (token_startstop_in != 2'b00);
  assign drop_vld = push_vld && !push_rdy;

`ifdef TTT_EVENT_TIMESTAMP_EN
  logic [1:0] stage_prev;
  logic [7:0] step_cnt;
  logic       step_inc;

  // One step completes when the core leaves transmit and returns to wait.
  assign step_inc = (stage_prev == 2'b11) && (stage_in == 2'b00);

  // Step counter; a push on an incrementing edge captures the old value.
  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      stage_prev <= 2'b00;
      step_cnt   <= 8'd0;
    end else begin
      stage_prev <= stage_in;
      if (step_inc) step_cnt <= step_cnt + 8'd1;
    end
  end

  assign push_dat        = '{proc_id: processor_id_in, startstop: token_startstop_in, timestamp: step_cnt};
  assign event_timestamp = head_dat.timestamp;
`else
  logic unused_stage;

  assign unused_stage    = ^stage_in;
  assign push_dat        = '{proc_id: processor_id_in, startstop: token_startstop_in};
  assign event_timestamp = 8'd0;
`endif

  ttt_event_fifo_buf #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clock_fast),
    .rst    (reset),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (push_rdy),
    .rd_rdy (pop),
    .rd_vld (event_valid),
    .rd_dat (head_dat),
    .count  (count)
  );

  assign event_proc_id   = head_dat.proc_id;
  assign event_startstop = head_dat.startstop;

  // Sticky drop flag; a new drop outranks a coincident clear.
  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_vld) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
